// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: load destination codes and INC/DEC bit positions shared by
// the register bank, the control unit and the B-bus multiplexer.
package reg_bank_pkg;
    localparam logic [2:0] LD_NONE    = 3'd0;
    localparam logic [2:0] LD_PC      = 3'd1;
    localparam logic [2:0] LD_R1      = 3'd2;
    localparam logic [2:0] LD_R2      = 3'd3;
    localparam logic [2:0] LD_R3      = 3'd4;
    localparam logic [2:0] LD_R       = 3'd5;
    localparam logic [2:0] LD_AR      = 3'd6;
    localparam logic [2:0] LD_ILLEGAL = 3'd7;
    localparam int IDX_PC = 0;
    localparam int IDX_R1 = 1;
    localparam int IDX_R2 = 2;
    localparam int IDX_R  = 3;
endpackage

// File: rtl/reg_bank_if.sv
// reg_bank_if: B-bus load/step controls and registered bank outputs.
// DEC is present only when REG_BANK_DEC_EN is defined.
interface reg_bank_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0] B_bus;
    logic [2:0]       LDsel;
    logic [3:0]       INC;
`ifdef REG_BANK_DEC_EN
    logic [3:0]       DEC;
`endif
    logic [WIDTH-1:0] PC, R1, R2, R3, R, AR;
    logic             Z;
    logic             ERR;
    modport master (
        output B_bus, LDsel, INC,
`ifdef REG_BANK_DEC_EN
        output DEC,
`endif
        input PC, R1, R2, R3, R, AR, Z, ERR
    );
    modport slave (
        input B_bus, LDsel, INC,
`ifdef REG_BANK_DEC_EN
        input DEC,
`endif
        output PC, R1, R2, R3, R, AR, Z, ERR
    );
endinterface

// File: rtl/reg_bank_cell.sv
// reg_cell: WIDTH-bit register, priority load > inc/dec > hold, async reset.
// With REG_BANK_DEC_EN, simultaneous inc and dec cancel.
module reg_cell #(parameter int WIDTH = 16) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
`ifdef REG_BANK_DEC_EN
    input  logic             dec,
`endif
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] q_q, q_d;
`ifdef REG_BANK_DEC_EN
    always_comb q_d = load ? d_i : (inc & ~dec) ? q_q + 1'b1 : (dec & ~inc) ? q_q - 1'b1 : q_q;
`else
    always_comb q_d = load ? d_i : inc ? q_q + 1'b1 : q_q;
`endif
    always_ff @(posedge clk or posedge reset)
        if (reset) q_q <= '0;
        else q_q <= q_d;
    assign q_o = q_q;
endmodule

// File: rtl/reg_bank.sv
// reg_bank: six B-bus destination registers with per-register increments,
// zero flag on R and sticky illegal-load flag. Optional: REG_BANK_DEC_EN.
module reg_bank
    import reg_bank_pkg::*;
#(parameter int WIDTH = 16) (
    input logic        clk,
    input logic        reset,
    reg_bank_if.slave  bus
);
    localparam int N = 6;
    logic [N-1:0]     ld, inc;
    logic [WIDTH-1:0] q [N];
    logic             err_q, err_d;
    // cell order follows the load codes: PC, R1, R2, R3, R, AR
    assign inc = {1'b0, bus.INC[IDX_R], 1'b0, bus.INC[IDX_R2], bus.INC[IDX_R1], bus.INC[IDX_PC]};
`ifdef REG_BANK_DEC_EN
    logic [N-1:0] dec;
    assign dec = {1'b0, bus.DEC[IDX_R], 1'b0, bus.DEC[IDX_R2], bus.DEC[IDX_R1], bus.DEC[IDX_PC]};
`endif
    for (genvar g = 0; g < N; g++) begin : g_cell
        assign ld[g] = bus.LDsel == 3'(g + 1);
        reg_cell #(.WIDTH(WIDTH)) u_cell (
            .clk   (clk),
            .reset (reset),
            .load  (ld[g]),
            .inc   (inc[g]),
`ifdef REG_BANK_DEC_EN
            .dec   (dec[g]),
`endif
            .d_i   (bus.B_bus),
            .q_o   (q[g])
        );
    end
    always_comb err_d = err_q | (bus.LDsel == LD_ILLEGAL);
    always_ff @(posedge clk or posedge reset)
        if (reset) err_q <= 1'b0;
        else err_q <= err_d;
    assign bus.PC  = q[LD_PC - 1];
    assign bus.R1  = q[LD_R1 - 1];
    assign bus.R2  = q[LD_R2 - 1];
    assign bus.R3  = q[LD_R3 - 1];
    assign bus.R   = q[LD_R - 1];
    assign bus.AR  = q[LD_AR - 1];
    assign bus.Z   = q[LD_R - 1] == '0;
    assign bus.ERR = err_q;
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: random and directed stimulus against an array-based model of
// the bank; also runs the decrement cases when REG_BANK_DEC_EN is defined.
module tb_reg_bank;
    logic clk = 0, reset = 1, active = 0;
    int checks = 0, errors = 0;
    reg_bank_if #(.WIDTH(16)) bus();
    reg_bank #(.WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;

    // model: index = load code - 1 (PC,R1,R2,R3,R,AR); ib = INC/DEC bit or -1
    logic [15:0] m [6];
    logic        merr;
    int          ib [6] = '{0, 1, 2, -1, 3, -1};

    function automatic int delta(int i);
        int d = 0;
        if (ib[i] >= 0) begin
            d = int'(bus.INC[ib[i]]);
`ifdef REG_BANK_DEC_EN
            d = d - int'(bus.DEC[ib[i]]);
`endif
        end
        return d;
    endfunction

    always @(posedge clk or posedge reset)
        if (reset) begin
            for (int i = 0; i < 6; i++) m[i] <= 16'h0;
            merr <= 1'b0;
        end else begin
            for (int i = 0; i < 6; i++)
                m[i] <= (bus.LDsel == 3'(i + 1)) ? bus.B_bus : m[i] + 16'(delta(i));
            if (bus.LDsel == 3'd7) merr <= 1'b1;
        end

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (active && !reset) begin
            chk("PC", bus.PC, m[0]);
            chk("R1", bus.R1, m[1]);
            chk("R2", bus.R2, m[2]);
            chk("R3", bus.R3, m[3]);
            chk("R",  bus.R,  m[4]);
            chk("AR", bus.AR, m[5]);
            chk("Z",  16'(bus.Z), 16'(m[4] == 16'h0));
            chk("ERR", 16'(bus.ERR), 16'(merr));
        end

    task automatic cyc(logic [2:0] ld, logic [3:0] inc, logic [3:0] dec, logic [15:0] b);
        bus.LDsel = ld;
        bus.INC   = inc;
        bus.B_bus = b;
`ifdef REG_BANK_DEC_EN
        bus.DEC   = dec;
`else
        if (dec != 4'h0) $display("note: dec ignored without REG_BANK_DEC_EN");
`endif
        @(posedge clk);
        #1;
        bus.LDsel = 3'd0;
        bus.INC   = 4'h0;
`ifdef REG_BANK_DEC_EN
        bus.DEC   = 4'h0;
`endif
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_PC"}, bus.PC, 16'h0);
        chk({tag, "_R"},  bus.R,  16'h0);
        chk({tag, "_AR"}, bus.AR, 16'h0);
        chk({tag, "_Z"},  16'(bus.Z), 16'h1);
        chk({tag, "_ERR"}, 16'(bus.ERR), 16'h0);
    endtask

    initial begin
        bus.LDsel = 3'd0;
        bus.INC   = 4'h0;
        bus.B_bus = 16'h0;
`ifdef REG_BANK_DEC_EN
        bus.DEC   = 4'h0;
`endif
        repeat (2) @(posedge clk);
        #1 chk_zero("rst");
        @(posedge clk);
        #1 reset = 0;
        active = 1;
        repeat (3) cyc(3'd0, 4'h0, 4'h0, 16'hFFFF);
        chk("idle_R1", bus.R1, 16'h0);
        for (int i = 1; i <= 6; i++) begin
            cyc(3'(i), 4'h0, 4'h0, 16'hA5C3);
            chk("ld_R3_pending", bus.R3, (i >= 4) ? 16'hA5C3 : 16'h0);
        end
        chk("ld_PC", bus.PC, 16'hA5C3);
        chk("ld_AR", bus.AR, 16'hA5C3);
        cyc(3'd5, 4'h0, 4'h0, 16'h0010);
        cyc(3'd5, 4'b1001, 4'h0, 16'h1234);
        chk("ldinc_R", bus.R, 16'h1234);
        chk("ldinc_PC", bus.PC, 16'hA5C4);
        cyc(3'd5, 4'h0, 4'h0, 16'hFFFF);
        cyc(3'd0, 4'b1000, 4'h0, 16'h0);
        chk("wrap_R", bus.R, 16'h0000);
        chk("wrap_Z", 16'(bus.Z), 16'h1);
`ifdef REG_BANK_DEC_EN
        cyc(3'd0, 4'h0, 4'b1000, 16'h0);
        chk("dec_R", bus.R, 16'hFFFF);
        chk("dec_Z", 16'(bus.Z), 16'h0);
        cyc(3'd2, 4'h0, 4'h0, 16'h0042);
        cyc(3'd0, 4'b0010, 4'b0010, 16'h0);
        chk("incdec_R1", bus.R1, 16'h0042);
`endif
        cyc(3'd7, 4'b0001, 4'h0, 16'h5555);
        chk("ill_PC", bus.PC, 16'hA5C5);
        chk("ill_AR", bus.AR, 16'hA5C3);
        chk("ill_ERR", 16'(bus.ERR), 16'h1);
        repeat (5) cyc(3'(1 + $urandom_range(0, 5)), 4'(($urandom)), 4'(($urandom)), 16'($urandom));
        chk("ill_sticky", 16'(bus.ERR), 16'h1);
        // mid-cycle async reset, then random traffic
        @(negedge clk);
        #2 reset = 1;
        #1 chk_zero("async");
        @(posedge clk);
        #1 reset = 0;
        repeat (3) cyc(3'd0, 4'h0, 4'h0, 16'h1);
        chk("post_ERR", 16'(bus.ERR), 16'h0);
        for (int n = 0; n < 400; n++)
            cyc(($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6)),
                4'($urandom), 4'($urandom), 16'($urandom_range(0, 3) == 0 ? 16'hFFFF : $urandom));
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
